hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RV32 core. It drives the F/D/E/M/W pipeline-register enables and clears and the E-stage forwarding muxes. It also owns the data-memory wait handshake: M is held while memory is busy, a bubble is injected into the W register, and a memory timeout is detected. It keeps a saturating stall-cycle counter for performance visibility.

Parameters:
TIMEOUT, 16, max consecutive wait cycles on one memory request before FAULT (≥2)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  async, active-high
Rs1D, Rs2D  in  5 each  D-stage source regs
Rs1E, Rs2E  in  5 each  E-stage source regs
RdE, RdM, RdW  in  5 each  destination regs per stage
RegWriteM, RegWriteW  in  1 each  writeback enables
ResultSrcE0  in  1  bit0 of ResultSrcE (1 = load in E)
PCSrcE  in  1  taken branch/jump resolved in E
MemReqM  in  1  load/store in M requesting memory
MemAckM  in  1  memory completes request this cycle
ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = ResultW, 10 = ALUResultM
StallF, StallD, StallE, StallM  out  1 each  hold register (enable low)
FlushD, FlushE, FlushW  out  1 each  synchronous clear to bubble
MemTimeout  out  1  sticky fault flag
StallCycles  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset (async): FSM=IDLE, wait counter=0, MemTimeout=0, StallCycles=0. Combinational outputs follow the IDLE equations below.
- Forwarding (combinational, A shown; B uses Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00. M has priority. x0 is never forwarded.
- lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = (MemReqM && !MemAckM) || state==FAULT.
- Ack in the same cycle as the request: zero stall. The ack cycle itself never stalls.
- FSM:
  - IDLE: memStall → WAIT, waitcnt=1.
  - WAIT: MemAckM → IDLE, waitcnt=0.
  - WAIT: MemReqM dropped without ack → IDLE (protocol violation tolerated).
  - WAIT: else waitcnt+1; when waitcnt==TIMEOUT-1 and still no ack → FAULT.
  - FAULT: absorbing until reset. MemTimeout=1; memStall held 1.
- Outputs when memStall=1:
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - FlushD=FlushE=0. memStall overrides lwStall and PCSrcE; the branch stays in E and is acted on after release.
- Outputs when memStall=0:
  - StallF=StallD=lwStall, StallE=StallM=0.
  - FlushD=PCSrcE, FlushE=lwStall||PCSrcE, FlushW=0.
- lwStall and PCSrcE are mutually exclusive (single instruction in E). If both are asserted (illegal), the equations still apply and an assertion flags it.
- StallCycles increments every cycle that StallF=1; it saturates at 2^CNT_W-1 and never wraps.
- Reset mid-WAIT or in FAULT returns to IDLE immediately. The counters clear.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - memwait_state_e enum (IDLE, WAIT, FAULT)
  - REG_ZERO constant
- One natural sub-module, hazard_fwd_unit: purely combinational forwarding for one operand, instantiated twice.
- FSM, stall/flush logic and counter stay in hazard_ctrl.

Test Plan:
- Forwarding: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. RegWriteM=0 → 01. All Rd=0 → 00.
- Load-use: ResultSrcE0=1, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for one cycle, StallCycles 0→1. With RdE=0 → no stall.
- Branch: PCSrcE=1 → FlushD=FlushE=1, no stalls, StallCycles unchanged.
- Memory wait: MemReqM=1, MemAckM low for 3 cycles then high → StallF/D/E/M=FlushW=1 for exactly 3 cycles. Release on the ack cycle. FSM back to IDLE. PCSrcE asserted during the wait is flushed only after release.
- Timeout: TIMEOUT=4, MemReqM=1, no ack → FAULT after 4 stall cycles. MemTimeout=1 sticky; stalls held. A later ack has no effect. Async reset mid-cycle clears everything.
- Saturation: CNT_W=4, continuous stall for 20 cycles → StallCycles=15 and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Data-memory wait tracking.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FAULT
  } memwait_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals exchanged with the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);

  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             ResultSrcE0;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemAckM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCycles;

  // Pipeline datapath side.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE0, PCSrcE, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemTimeout, StallCycles
  );

  // Hazard controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE0, PCSrcE, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemTimeout, StallCycles
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one E-stage operand; M has priority, x0 never forwarded.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_e   fwd
);

  // Priority select between M and W results.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use/branch handling,
// data-memory wait with timeout, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);

  localparam int unsigned WcntW = $clog2(TIMEOUT + 1);

  memwait_state_e   state_q, state_d;
  logic [WcntW-1:0] waitcnt_q, waitcnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  fwd_sel_e fwd_a, fwd_b;
  logic     lw_stall, mem_stall;
  logic     stall_f;

  hazard_fwd_unit u_fwd_a (
    .rs          (hif.Rs1E),
    .rd_m        (hif.RdM),
    .rd_w        (hif.RdW),
    .reg_write_m (hif.RegWriteM),
    .reg_write_w (hif.RegWriteW),
    .fwd         (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs          (hif.Rs2E),
    .rd_m        (hif.RdM),
    .rd_w        (hif.RdW),
    .reg_write_m (hif.RegWriteM),
    .reg_write_w (hif.RegWriteW),
    .fwd         (fwd_b)
  );

  assign hif.ForwardAE = fwd_a;
  assign hif.ForwardBE = fwd_b;

  assign lw_stall  = hif.ResultSrcE0 && (hif.RdE != REG_ZERO) &&
                     ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
  // The ack cycle never stalls; FAULT holds the pipe forever.
  assign mem_stall = (hif.MemReqM && !hif.MemAckM) || (state_q == FAULT);

  // Memory-wait next state and wait-cycle count.
  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_stall) begin
          state_d   = WAIT;
          waitcnt_d = WcntW'(1);
        end
      end
      WAIT: begin
        // A dropped request without ack is tolerated and simply ends the wait.
        if (hif.MemAckM || !hif.MemReqM) begin
          state_d   = IDLE;
          waitcnt_d = '0;
        end else if (waitcnt_q == WcntW'(TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          waitcnt_d = waitcnt_q + 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d   = IDLE;
        waitcnt_d = '0;
      end
    endcase
  end

  // Memory-wait state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      waitcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
    end
  end

  // Stall/flush decode; a memory stall freezes everything including a pending branch.
  always_comb begin
    stall_f    = lw_stall;
    hif.StallD = lw_stall;
    hif.StallE = 1'b0;
    hif.StallM = 1'b0;
    hif.FlushD = hif.PCSrcE;
    hif.FlushE = lw_stall || hif.PCSrcE;
    hif.FlushW = 1'b0;
    if (mem_stall) begin
      stall_f    = 1'b1;
      hif.StallD = 1'b1;
      hif.StallE = 1'b1;
      hif.StallM = 1'b1;
      hif.FlushD = 1'b0;
      hif.FlushE = 1'b0;
      hif.FlushW = 1'b1;
    end
  end

  assign hif.StallF      = stall_f;
  assign hif.MemTimeout  = (state_q == FAULT);
  assign hif.StallCycles = stall_cnt_q;

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // A single E-stage instruction cannot be both a load and a taken branch.
  a_lw_branch_excl : assert property (@(posedge clk) disable iff (reset)
    !(lw_stall && hif.PCSrcE));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle model compare plus directed literals.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: consecutive unacked cycles of the current request, and fault latch.
  int m_waits = 0;
  bit m_fault = 1'b0;
  int m_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input logic [4:0] rs);
    if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2;
    if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 1;
    return 0;
  endfunction

  function automatic bit exp_lw();
    return hif.ResultSrcE0 && hif.RdE != 0 && (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
  endfunction

  function automatic bit exp_ms();
    return m_fault || (hif.MemReqM && !hif.MemAckM);
  endfunction

  // Model advance on the same edge the DUT uses.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_waits <= 0;
      m_fault <= 1'b0;
      m_cnt   <= 0;
    end else begin
      if (!m_fault) begin
        if (hif.MemReqM && !hif.MemAckM) begin
          m_waits <= m_waits + 1;
          if (m_waits + 1 == TIMEOUT) m_fault <= 1'b1;
        end else begin
          m_waits <= 0;
        end
      end
      if ((exp_ms() || exp_lw()) && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    bit ms, lw, pc;
    ms = exp_ms();
    lw = exp_lw();
    pc = hif.PCSrcE;
    check("ForwardAE",   int'(hif.ForwardAE),   exp_fwd(hif.Rs1E));
    check("ForwardBE",   int'(hif.ForwardBE),   exp_fwd(hif.Rs2E));
    check("StallF",      int'(hif.StallF),      int'(ms || lw));
    check("StallD",      int'(hif.StallD),      int'(ms || lw));
    check("StallE",      int'(hif.StallE),      int'(ms));
    check("StallM",      int'(hif.StallM),      int'(ms));
    check("FlushD",      int'(hif.FlushD),      int'(!ms && pc));
    check("FlushE",      int'(hif.FlushE),      int'(!ms && (lw || pc)));
    check("FlushW",      int'(hif.FlushW),      int'(ms));
    check("MemTimeout",  int'(hif.MemTimeout),  int'(m_fault));
    check("StallCycles", int'(hif.StallCycles), m_cnt);
  end

  task automatic zero_inputs();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
    hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
    hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.ResultSrcE0 = 0; hif.PCSrcE = 0; hif.MemReqM = 0; hif.MemAckM = 0;
  endtask

  // Advance to just after the next active edge with all inputs idle.
  task automatic step();
    @(posedge clk);
    #1;
    zero_inputs();
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    repeat (2) @(posedge clk);
    #2;
    check("rst_StallCycles", int'(hif.StallCycles), 0);
    check("rst_MemTimeout",  int'(hif.MemTimeout),  0);
    check("rst_StallF",      int'(hif.StallF),      0);
    reset = 1'b0;

    // Forwarding priorities.
    step();
    hif.Rs1E = 5; hif.Rs2E = 5; hif.RdM = 5; hif.RdW = 5;
    hif.RegWriteM = 1; hif.RegWriteW = 1;
    #1;
    check("fwd_mem_A", int'(hif.ForwardAE), 2);
    check("fwd_mem_B", int'(hif.ForwardBE), 2);
    step();
    hif.Rs1E = 5; hif.RdM = 5; hif.RdW = 5; hif.RegWriteW = 1;
    #1;
    check("fwd_wb_A", int'(hif.ForwardAE), 1);
    step();
    hif.RegWriteM = 1; hif.RegWriteW = 1;
    #1;
    check("fwd_x0_A", int'(hif.ForwardAE), 0);
    check("fwd_x0_B", int'(hif.ForwardBE), 0);
    step();
    hif.Rs1E = 5; hif.RdM = 5; hif.Rs2E = 7; hif.RdW = 7;
    hif.RegWriteM = 1; hif.RegWriteW = 1;
    #1;
    check("fwd_mix_A", int'(hif.ForwardAE), 2);
    check("fwd_mix_B", int'(hif.ForwardBE), 1);

    // Load-use stall, one cycle.
    step();
    hif.ResultSrcE0 = 1; hif.RdE = 3; hif.Rs2D = 3;
    #1;
    check("lw_StallF", int'(hif.StallF), 1);
    check("lw_StallD", int'(hif.StallD), 1);
    check("lw_FlushE", int'(hif.FlushE), 1);
    check("lw_StallE", int'(hif.StallE), 0);
    step();
    #1;
    check("lw_cnt", int'(hif.StallCycles), 1);
    hif.ResultSrcE0 = 1;
    #1;
    check("lw_x0_StallF", int'(hif.StallF), 0);

    // Taken branch.
    step();
    hif.PCSrcE = 1;
    #1;
    check("br_FlushD", int'(hif.FlushD), 1);
    check("br_FlushE", int'(hif.FlushE), 1);
    check("br_StallF", int'(hif.StallF), 0);
    step();
    #1;
    check("br_cnt", int'(hif.StallCycles), 1);

    // Memory wait of three cycles with a pending branch.
    for (int i = 0; i < 3; i++) begin
      step();
      hif.MemReqM = 1; hif.PCSrcE = 1;
      #1;
      check("mw_StallM", int'(hif.StallM), 1);
      check("mw_FlushW", int'(hif.FlushW), 1);
      check("mw_FlushD", int'(hif.FlushD), 0);
    end
    step();
    hif.MemReqM = 1; hif.MemAckM = 1; hif.PCSrcE = 1;
    #1;
    check("ack_StallF", int'(hif.StallF), 0);
    check("ack_FlushD", int'(hif.FlushD), 1);
    check("ack_FlushE", int'(hif.FlushE), 1);
    step();
    #1;
    check("mw_cnt", int'(hif.StallCycles), 4);

    // Timeout after TIMEOUT unacked cycles.
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      hif.MemReqM = 1;
      #1;
      check("to_pre_MemTimeout", int'(hif.MemTimeout), 0);
      check("to_pre_StallF", int'(hif.StallF), 1);
    end
    step();
    hif.MemReqM = 1;
    #1;
    check("to_MemTimeout", int'(hif.MemTimeout), 1);
    step();
    hif.MemReqM = 1; hif.MemAckM = 1;
    #1;
    check("to_ack_StallF",     int'(hif.StallF),     1);
    check("to_ack_MemTimeout", int'(hif.MemTimeout), 1);
    step();
    #1;
    check("to_idle_StallE", int'(hif.StallE), 1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_MemTimeout",  int'(hif.MemTimeout),  0);
    check("arst_StallCycles", int'(hif.StallCycles), 0);
    check("arst_StallF",      int'(hif.StallF),      0);
    step();
    reset = 1'b0;

    // Saturation of the stall counter.
    for (int i = 0; i < 20; i++) begin
      step();
      hif.ResultSrcE0 = 1; hif.RdE = 3; hif.Rs1D = 3;
    end
    step();
    #1;
    check("sat_cnt", int'(hif.StallCycles), CNT_MAX);
    step();
    hif.ResultSrcE0 = 1; hif.RdE = 3; hif.Rs1D = 3;
    step();
    #1;
    check("sat_hold", int'(hif.StallCycles), CNT_MAX);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
